lcd_display_driver: RTL and testbench

//  Downstream consumer of the 32-entry character-lookup stage. Drives an HD44780-compatible
//  16x2 character LCD over its 8-bit write-only bus. After reset it runs the power-up

---
 rtl/lcd_display_driver.sv | 168 ++++++++++++++++
 tb/tb_lcd_display_driver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_display_driver.sv
// rtl/lcd_display_driver.sv - HD44780 16x2 refresh driver: power-up wait, init commands, continuous 32-char refresh
module lcd_display_driver #(
  parameter int POWERUP_CYC = 750000,
  parameter int E_PULSE     = 12,
  parameter int CMD_WAIT    = 2000,
  parameter int CLEAR_WAIT  = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] char_data,
  output logic [4:0] char_index,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_on,
  output logic       lcd_blon,
  output logic       init_done,
  output logic       frame_done
);

  localparam int MAX_A = (POWERUP_CYC > E_PULSE) ? POWERUP_CYC : E_PULSE;
  localparam int MAX_B = (CMD_WAIT > CLEAR_WAIT) ? CMD_WAIT : CLEAR_WAIT;
  localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAXP + 1);

  localparam logic [CW-1:0] PW_LAST    = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(E_PULSE - 1);
  localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_WAIT - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_WAIT - 1);

  typedef enum logic [2:0] {S_PWRUP, S_INIT, S_ADDR1, S_CHARS1, S_ADDR2, S_CHARS2} state_t;
  typedef enum logic [1:0] {P_LOAD, P_SETUP, P_PULSE, P_WAIT} phase_t;

  state_t        state, state_nx;
  phase_t        phase, phase_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CW-1:0] wait_last;
  logic [1:0]    init_step;
  logic          byte_done;
  logic          is_clear;
  logic [7:0]    byte_sel;
  logic          is_data;

  // The clear command needs the long settle time; a data byte of 0x01 does not.
  assign is_clear  = (lcd_data == 8'h01) && !lcd_rs;
  assign wait_last = is_clear ? CLEAR_LAST : CMD_LAST;
  assign lcd_rw    = 1'b0;

  // State, byte phase and shared timing counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_PWRUP;
      phase <= P_LOAD;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state: power-up countdown, then LOAD/SETUP/PULSE/WAIT per byte, sequencing on each byte end.
  always_comb begin
    state_nx  = state;
    phase_nx  = phase;
    cnt_nx    = cnt + 1'b1;
    byte_done = 1'b0;
    case (state)
      S_PWRUP: begin
        if (cnt == PW_LAST) begin
          state_nx = S_INIT;
          phase_nx = P_LOAD;
          cnt_nx   = '0;
        end
      end
      default: begin
        case (phase)
          P_LOAD: begin
            phase_nx = P_SETUP;
            cnt_nx   = '0;
          end
          P_SETUP: begin
            phase_nx = P_PULSE;
            cnt_nx   = '0;
          end
          P_PULSE: begin
            if (cnt == PULSE_LAST) begin
              phase_nx = P_WAIT;
              cnt_nx   = '0;
            end
          end
          P_WAIT: begin
            if (cnt == wait_last) begin
              phase_nx  = P_LOAD;
              cnt_nx    = '0;
              byte_done = 1'b1;
              case (state)
                S_INIT:   if (init_step == 2'd3) state_nx = S_ADDR1;
                S_ADDR1:  state_nx = S_CHARS1;
                S_CHARS1: if (char_index == 5'd15) state_nx = S_ADDR2;
                S_ADDR2:  state_nx = S_CHARS2;
                S_CHARS2: if (char_index == 5'd31) state_nx = S_ADDR1;
                default:  state_nx = state;
              endcase
            end
          end
        endcase
      end
    endcase
  end

  // Outputs: enable strobe only in PULSE, and the byte to load for the current state.
  always_comb begin
    lcd_en   = 1'b0;
    byte_sel = 8'h00;
    is_data  = 1'b0;
    if (state != S_PWRUP && phase == P_PULSE) lcd_en = 1'b1;
    case (state)
      S_INIT: begin
        case (init_step)
          2'd0:    byte_sel = 8'h38;
          2'd1:    byte_sel = 8'h0C;
          2'd2:    byte_sel = 8'h01;
          default: byte_sel = 8'h06;
        endcase
      end
      S_ADDR1: byte_sel = 8'h80;
      S_ADDR2: byte_sel = 8'hC0;
      S_CHARS1, S_CHARS2: begin
        byte_sel = char_data;
        is_data  = 1'b1;
      end
      default: byte_sel = 8'h00;
    endcase
  end

  // Registered bus, screen position and status flags; index moves only when a WAIT ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      lcd_data   <= 8'h00;
      lcd_rs     <= 1'b0;
      char_index <= 5'd0;
      init_step  <= 2'd0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
      lcd_on     <= 1'b0;
      lcd_blon   <= 1'b0;
    end else begin
      lcd_on     <= 1'b1;
      lcd_blon   <= 1'b1;
      frame_done <= 1'b0;
      if (state != S_PWRUP && phase == P_LOAD) begin
        lcd_data <= byte_sel;
        lcd_rs   <= is_data;
      end
      if (byte_done) begin
        if (state == S_INIT) begin
          init_step <= init_step + 2'd1;
          if (init_step == 2'd3) init_done <= 1'b1;
        end
        if (state == S_CHARS1 || state == S_CHARS2) char_index <= char_index + 5'd1;
        if (state == S_CHARS2 && char_index == 5'd31) frame_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_display_driver.sv
// tb/tb_lcd_display_driver.sv - scoreboard bench for lcd_display_driver with random lookup tables
module tb_lcd_display_driver;

  localparam int PWR   = 20;
  localparam int EP    = 2;
  localparam int CWT   = 5;
  localparam int CLW   = 10;
  localparam int FRAME = 34 * (2 + EP + CWT);

  logic       clk;
  logic       reset;
  logic [7:0] char_data;
  logic [4:0] char_index;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, init_done, frame_done;

  logic [7:0] lut [32];
  assign char_data = lut[char_index];

  lcd_display_driver #(
    .POWERUP_CYC(PWR), .E_PULSE(EP), .CMD_WAIT(CWT), .CLEAR_WAIT(CLW)
  ) dut (
    .clk(clk), .reset(reset), .char_data(char_data), .char_index(char_index),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en),
    .lcd_on(lcd_on), .lcd_blon(lcd_blon), .init_done(init_done), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       rs;
    logic [4:0] idx;
    int         gap;
    bit         init_last;
    bit         frame_last;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   first_item;
  int   prev_wait;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Expected byte stream: first byte follows the power-up wait, later ones follow the previous byte's full slot.
  task automatic push_item(input logic [7:0] d, input logic rs, input int idx, input bit il, input bit fl);
    exp_t e;
    e.data       = d;
    e.rs         = rs;
    e.idx        = 5'(idx);
    e.gap        = first_item ? (PWR + 2) : (2 + EP + prev_wait);
    e.init_last  = il;
    e.frame_last = fl;
    sb.push_back(e);
    first_item = 1'b0;
    prev_wait  = (d == 8'h01 && !rs) ? CLW : CWT;
  endtask

  task automatic push_run(input int frames);
    logic [7:0] init_cmds [4];
    init_cmds[0] = 8'h38; init_cmds[1] = 8'h0C; init_cmds[2] = 8'h01; init_cmds[3] = 8'h06;
    sb.delete();
    first_item = 1'b1;
    prev_wait  = 0;
    for (int i = 0; i < 4; i++) push_item(init_cmds[i], 1'b0, 0, i == 3, 1'b0);
    for (int f = 0; f < frames; f++) begin
      push_item(8'h80, 1'b0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) push_item(lut[i], 1'b1, i, 1'b0, 1'b0);
      push_item(8'hC0, 1'b0, 16, 1'b0, 1'b0);
      for (int i = 16; i < 32; i++) push_item(lut[i], 1'b1, i, 1'b0, i == 31);
    end
  endtask

  // Monitor: pops the scoreboard on every enable rise and checks timing/status every cycle.
  int         since, last_rise, en_len, exp_fd, exp_init, fd_last;
  logic       prev_en;
  logic [7:0] prev_data;
  logic [4:0] prev_idx;
  exp_t       got;

  always @(negedge clk) begin
    if (reset) begin
      since = 0; last_rise = 0; en_len = 0;
      exp_fd = -1; exp_init = -1; fd_last = -1;
      prev_en = 1'b0; prev_data = lcd_data; prev_idx = char_index;
    end else begin
      chk("lcd_rw", lcd_rw, 0);
      if (since >= 1) begin
        chk("lcd_on", lcd_on, 1);
        chk("lcd_blon", lcd_blon, 1);
      end
      if (lcd_en) begin
        chk("data_stable_en", lcd_data, prev_data);
        chk("index_stable_en", char_index, prev_idx);
        en_len++;
      end
      if (lcd_en && !prev_en) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_byte: got 0x%0h rs=%0d expected none at %0t", lcd_data, lcd_rs, $time);
        end else begin
          got = sb.pop_front();
          chk("byte_data", lcd_data, got.data);
          chk("byte_rs", lcd_rs, got.rs);
          chk("byte_index", char_index, got.idx);
          chk("byte_gap", since - last_rise, got.gap);
          if (got.init_last)  exp_init = since + EP + CWT;
          if (got.frame_last) exp_fd   = since + EP + CWT;
        end
        last_rise = since;
      end
      if (!lcd_en && prev_en) begin
        chk("en_width", en_len, EP);
        en_len = 0;
      end
      chk("frame_done", frame_done, since == exp_fd);
      chk("init_done", init_done, (exp_init >= 0) && (since >= exp_init));
      if (frame_done) begin
        chk("wrap_index", char_index, 0);
        if (fd_last >= 0) chk("frame_period", since - fd_last, FRAME);
        fd_last = since;
      end
      prev_en = lcd_en; prev_data = lcd_data; prev_idx = char_index;
      since++;
    end
  end

  task automatic wait_sb(input int thr, input string nm);
    bit hit = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      #1;
      if (sb.size() <= thr) begin hit = 1'b1; break; end
    end
    if (!hit) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout_%s: got %0d pending expected <=%0d", nm, sb.size(), thr);
    end
  endtask

  // Assert reset while a data byte's enable is high, then check the forced state on the next edge.
  task automatic reset_mid_pulse(input int thr);
    bit hit = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      #1;
      if (sb.size() <= thr && lcd_en && lcd_rs) begin hit = 1'b1; break; end
    end
    if (!hit) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout_midpulse: got %0d pending expected <=%0d", sb.size(), thr);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_lcd_en", lcd_en, 0);
    chk("rst_char_index", char_index, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_lcd_data", lcd_data, 0);
    chk("rst_lcd_rs", lcd_rs, 0);
    chk("rst_lcd_on", lcd_on, 0);
    chk("rst_lcd_blon", lcd_blon, 0);
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 32; i++) lut[i] = 8'(8'h41 + i);
    @(posedge clk);
    #1;
    chk("reset_lcd_en", lcd_en, 0);
    chk("reset_char_index", char_index, 0);
    chk("reset_lcd_data", lcd_data, 0);
    chk("reset_init_done", init_done, 0);
    chk("reset_lcd_on", lcd_on, 0);

    // Ascending table: two complete frames, then reset during a data pulse of the third.
    push_run(3);
    release_reset();
    reset_mid_pulse(30);

    // Random table, reset at a random point inside the second frame.
    for (int i = 0; i < 32; i++) lut[i] = 8'($urandom_range(32, 126));
    push_run(3);
    release_reset();
    reset_mid_pulse($urandom_range(40, 70));

    // Random table, run well past two frame wraps.
    for (int i = 0; i < 32; i++) lut[i] = 8'($urandom_range(32, 126));
    push_run(3);
    release_reset();
    wait_sb(20, "final_run");
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
